queen_solver_ctrl: RTL

Backtracking sequencer for the N-queens search engine. It owns the row index and the per-row column registers, checks safety in one cycle per placement, and steps forward or back through the search. Every complete placement is emitted as a solution over a valid/ready handshake. The block sits between the host start/done interface and the downstream solution sink.

---
 rtl/queen_pkg.sv | 16 +
 rtl/queen_solver_ctrl_counter.sv | 38 +++
 rtl/queen_solver_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/queen_pkg.sv
// Shared types and constants for the N-queens backtracking sequencer.
package queen_pkg;

    localparam int N_DEF = 8;
    localparam int W_DEF = 3;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        BACK  = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/queen_solver_ctrl_counter.sv
// Loadable up/down counter used as the search row index.
module counter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         count_up,
    input  logic         count_down,
    output logic [N-1:0] count
);

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_data;
        end else if (count_up) begin
            count_d = count_q + N'(1);
        end else if (count_down) begin
            count_d = count_q - N'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/queen_solver_ctrl.sv
// N-queens backtracking sequencer: one placement or backtrack step per cycle.
// Define QUEEN_FIRST_ONLY_EN to stop after the first accepted solution.
module queen_solver_ctrl
    import queen_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sol_ready,
    output logic             sol_valid,
    output logic [N*W-1:0]   sol_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sol_count
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    state_t             state_q, state_d;
    logic [N*W-1:0]     cols_q, cols_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       row;
    logic               row_load, row_up, row_down;
    logic [W-1:0]       cur_col, prev_col, k_col;
    logic [W:0]         col_diff, row_diff;
    logic               safe;

    counter #(.N(W)) u_row (
        .clk        (clk),
        .reset      (reset),
        .load       (row_load),
        .load_data  ('0),
        .count_up   (row_up),
        .count_down (row_down),
        .count      (row)
    );

    // Diagonal test compares |col delta| against row delta, both W+1 bits unsigned.
    always_comb begin
        cur_col  = cols_q[int'(row)*W +: W];
        prev_col = cols_q[int'(row - W'(1))*W +: W];
        safe     = 1'b1;
        k_col    = '0;
        col_diff = '0;
        row_diff = '0;
        for (int k = 0; k < N; k++) begin
            if (k < int'(row)) begin
                k_col    = cols_q[k*W +: W];
                col_diff = ({1'b0, k_col} >= {1'b0, cur_col}) ?
                           ({1'b0, k_col} - {1'b0, cur_col}) :
                           ({1'b0, cur_col} - {1'b0, k_col});
                row_diff = {1'b0, row} - (W+1)'(k);
                if ((k_col == cur_col) || (col_diff == row_diff)) begin
                    safe = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cols_d   = cols_q;
        cnt_d    = cnt_q;
        row_load = 1'b0;
        row_up   = 1'b0;
        row_down = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    row_load     = 1'b1;
                    cols_d[W-1:0] = '0;
                    cnt_d        = '0;
                    state_d      = CHECK;
                end
            end
            CHECK: begin
                if (safe) begin
                    if (row == LAST) begin
                        state_d = EMIT;
                    end else begin
                        row_up = 1'b1;
                        cols_d[(int'(row)+1)*W +: W] = '0;
                    end
                end else if (cur_col != LAST) begin
                    cols_d[int'(row)*W +: W] = cur_col + W'(1);
                end else begin
                    state_d = BACK;
                end
            end
            BACK: begin
                if (row == '0) begin
                    state_d = DONE;
                end else begin
                    row_down = 1'b1;
                    if (prev_col != LAST) begin
                        cols_d[int'(row - W'(1))*W +: W] = prev_col + W'(1);
                        state_d = CHECK;
                    end
                end
            end
            EMIT: begin
                if (sol_ready) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`ifdef QUEEN_FIRST_ONLY_EN
                    state_d = DONE;
`else
                    // Treat the accepted solution as a failed placement in the last row.
                    if (cur_col != LAST) begin
                        cols_d[int'(row)*W +: W] = cur_col + W'(1);
                        state_d = CHECK;
                    end else begin
                        state_d = BACK;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cols_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cols_q  <= cols_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sol_valid = (state_q == EMIT);
    assign sol_data  = cols_q;
    assign busy      = (state_q == CHECK) || (state_q == BACK) || (state_q == EMIT);
    assign done      = (state_q == DONE);
    assign sol_count = cnt_q;

endmodule
